reg_file_mp: RTL and testbench

Parametrised multi-port register file and successor to the 4x8, 1-write/2-read `reg_file`. It adds configurable width, depth, read and write port counts, per-byte write enables, and same-cycle write-to-read bypass. It also adds an optional registered read stage, an optional hardwired-zero register 0, per-entry written-since-reset tracking, and write-conflict reporting. It sits in the datapath as the operand store feeding ALU-side read ports.

---
 rtl/reg_file_pkg.sv | 45 ++++
 rtl/reg_file_rd_port.sv | 69 ++++++
 rtl/reg_file_mp.sv | 111 +++++++++++
 tb/tb_reg_file_mp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing helpers and lane-merge/priority functions for the multi-port register file.
package reg_file_pkg;

  // Upper bounds for the fixed-width helper functions below.
  localparam int unsigned MAX_WIDTH = 128;
  localparam int unsigned MAX_NB    = MAX_WIDTH / 8;
  localparam int unsigned MAX_WR    = 2;

  typedef logic [MAX_WIDTH-1:0] word_t;
  typedef logic [MAX_NB-1:0]    lanes_t;

  // Number of byte lanes in a WIDTH-bit word.
  function automatic int unsigned calc_nb(input int unsigned width);
    return width / 8;
  endfunction

  // Address width for a power-of-two depth.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Replace the lanes selected by be with the matching lanes of new_w.
  function automatic word_t lane_merge(input word_t old_w, input word_t new_w, input lanes_t be);
    word_t r;
    r = old_w;
    for (int unsigned b = 0; b < MAX_NB; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // Per lane, take the data of the highest-numbered port enabling that lane.
  function automatic word_t port_win(input lanes_t [MAX_WR-1:0] lane_en,
                                     input word_t  [MAX_WR-1:0] data);
    word_t r;
    r = '0;
    for (int unsigned p = 0; p < MAX_WR; p++) begin
      for (int unsigned b = 0; b < MAX_NB; b++) begin
        if (lane_en[p][b]) r[b*8 +: 8] = data[p][b*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: address mux, write bypass, zero-register override, optional output register.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned RD_REG   = 0,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DEPTH-1:0][WIDTH-1:0]    mem,
  input  logic [DEPTH-1:0]               vld,
  input  logic [AW-1:0]                  rd_addr,
  input  logic [MAX_WR-1:0]              wr_act,
  input  logic [MAX_WR-1:0][AW-1:0]      wr_addr,
  input  lanes_t [MAX_WR-1:0]            wr_be,
  input  word_t  [MAX_WR-1:0]            wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           rd_valid
);

  logic [WIDTH-1:0] data_c;
  logic             valid_c;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  // Stored value, optionally overlaid with same-cycle write lanes, then zero-register override.
  always_comb begin : read_mux
    lanes_t [MAX_WR-1:0] le;
    lanes_t              any;
    logic [WIDTH-1:0]    stored;
    logic [WIDTH-1:0]    merged;
    any = '0;
    for (int unsigned p = 0; p < MAX_WR; p++) begin
      le[p] = (wr_act[p] && (wr_addr[p] == rd_addr)) ? wr_be[p] : '0;
      any   = any | le[p];
    end
    stored  = mem[rd_addr];
    merged  = WIDTH'(lane_merge(word_t'(stored), port_win(le, wr_data), any));
    data_c  = stored;
    valid_c = vld[rd_addr];
    if ((BYPASS != 0) && (|any)) begin
      data_c  = merged;
      valid_c = 1'b1;
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      data_c  = '0;
      valid_c = 1'b1;
    end
  end

  // Registered read stage; only selected when RD_REG is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= data_c;
      rd_valid_q <= valid_c;
    end
  end

  assign rd_data  = (RD_REG != 0) ? rd_data_q  : data_c;
  assign rd_valid = (RD_REG != 0) ? rd_valid_q : valid_c;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with byte enables, bypass and conflict reporting.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned RD_REG   = 0,
  parameter int unsigned ZERO_REG = 0,
  localparam int unsigned NB      = calc_nb(WIDTH),
  localparam int unsigned AW      = calc_aw(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]       wr_addr,
  input  logic [NUM_WR-1:0][NB-1:0]       wr_be,
  input  logic [NUM_WR-1:0][WIDTH-1:0]    wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]       rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_valid,
  output logic                            wr_conflict
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            vld_q, vld_d;

  logic [MAX_WR-1:0]           act_pad;
  logic [MAX_WR-1:0][AW-1:0]   addr_pad;
  lanes_t [MAX_WR-1:0]         be_pad;
  word_t  [MAX_WR-1:0]         data_pad;
  logic                        conflict_c;

  // Widen write ports to the fixed helper width; drop writes to a hardwired zero entry.
  always_comb begin
    act_pad  = '0;
    addr_pad = '0;
    be_pad   = '0;
    data_pad = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      act_pad[p]  = wr_en[p] && !((ZERO_REG != 0) && (wr_addr[p] == '0));
      addr_pad[p] = wr_addr[p];
      be_pad[p]   = lanes_t'(wr_be[p]);
      data_pad[p] = word_t'(wr_data[p]);
    end
  end

  // Next array contents: per entry, merge the winning lanes of all ports addressing it.
  always_comb begin : write_merge
    lanes_t [MAX_WR-1:0] le;
    lanes_t              any;
    mem_d = mem_q;
    vld_d = vld_q;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      any = '0;
      for (int unsigned p = 0; p < MAX_WR; p++) begin
        le[p] = (act_pad[p] && (addr_pad[p] == AW'(e))) ? be_pad[p] : '0;
        any   = any | le[p];
      end
      if (|any) begin
        mem_d[e] = WIDTH'(lane_merge(word_t'(mem_q[e]), port_win(le, data_pad), any));
        vld_d[e] = 1'b1;
      end
    end
  end

  // Two ports hitting the same entry with at least one shared lane.
  always_comb begin
    conflict_c = act_pad[0] && act_pad[1] && (addr_pad[0] == addr_pad[1]) &&
                 (|(be_pad[0] & be_pad[1]));
  end

  // Array, valid bits and conflict pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q       <= '0;
      vld_q       <= '0;
      wr_conflict <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      vld_q       <= vld_d;
      wr_conflict <= conflict_c;
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    reg_file_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .BYPASS   (BYPASS),
      .RD_REG   (RD_REG),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .mem      (mem_q),
      .vld      (vld_q),
      .rd_addr  (rd_addr[r]),
      .wr_act   (act_pad),
      .wr_addr  (addr_pad),
      .wr_be    (be_pad),
      .wr_data  (data_pad),
      .rd_data  (rd_data[r]),
      .rd_valid (rd_valid[r])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default, no-bypass and zero-reg/registered-read configurations.
module tb_reg_file_mp;

  typedef struct packed {
    logic [1:0]       en;
    logic [1:0][1:0]  wa;
    logic [1:0][1:0]  be;
    logic [1:0][15:0] wd;
    logic [1:0][1:0]  ra;
  } in_t;

  typedef struct {
    in_t         i;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  ev;
    logic        ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  im, inb, iz;

  logic [1:0][15:0] rd_m, rd_n, rd_z;
  logic [1:0]       v_m, v_n, v_z;
  logic             cf_m, cf_n, cf_z;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_file_mp u_main (
    .clk(clk), .rst(rst), .wr_en(im.en), .wr_addr(im.wa), .wr_be(im.be),
    .wr_data(im.wd), .rd_addr(im.ra), .rd_data(rd_m), .rd_valid(v_m), .wr_conflict(cf_m)
  );

  reg_file_mp #(.BYPASS(0), .RD_REG(0), .ZERO_REG(0)) u_nb (
    .clk(clk), .rst(rst), .wr_en(inb.en), .wr_addr(inb.wa), .wr_be(inb.be),
    .wr_data(inb.wd), .rd_addr(inb.ra), .rd_data(rd_n), .rd_valid(v_n), .wr_conflict(cf_n)
  );

  reg_file_mp #(.BYPASS(1), .RD_REG(1), .ZERO_REG(1)) u_zr (
    .clk(clk), .rst(rst), .wr_en(iz.en), .wr_addr(iz.wa), .wr_be(iz.be),
    .wr_data(iz.wd), .rd_addr(iz.ra), .rd_data(rd_z), .rd_valid(v_z), .wr_conflict(cf_z)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int en, input int a0, input int b0, input int d0,
                              input int a1, input int b1, input int d1,
                              input int r0, input int r1, input int e0, input int e1,
                              input int v0, input int v1, input int c);
    vec_t v;
    v.i.en    = 2'(en);
    v.i.wa[0] = 2'(a0);
    v.i.be[0] = 2'(b0);
    v.i.wd[0] = 16'(d0);
    v.i.wa[1] = 2'(a1);
    v.i.be[1] = 2'(b1);
    v.i.wd[1] = 16'(d1);
    v.i.ra[0] = 2'(r0);
    v.i.ra[1] = 2'(r1);
    v.e0      = 16'(e0);
    v.e1      = 16'(e1);
    v.ev      = {1'(v1), 1'(v0)};
    v.ec      = 1'(c);
    return v;
  endfunction

  vec_t vt[17];

  initial begin
    // en, a0,be0,d0, a1,be1,d1, ra0,ra1, exp0,exp1, v0,v1, conflict
    vt[0]  = mk(0, 0,0,0,       0,0,0,       0,1, 0,0,             0,0, 0);
    vt[1]  = mk(0, 0,0,0,       0,0,0,       2,3, 0,0,             0,0, 0);
    vt[2]  = mk(1, 2,3,'hBEEF,  0,0,0,       3,1, 0,0,             0,0, 0);
    vt[3]  = mk(0, 0,0,0,       0,0,0,       2,2, 'hBEEF,'hBEEF,   1,1, 0);
    vt[4]  = mk(1, 1,3,'h1234,  0,0,0,       0,2, 0,'hBEEF,        0,1, 0);
    vt[5]  = mk(1, 1,1,'hAAAA,  0,0,0,       1,1, 'h12AA,'h12AA,   1,1, 0);
    vt[6]  = mk(1, 1,2,'h5600,  0,0,0,       1,3, 'h56AA,0,        1,0, 0);
    vt[7]  = mk(3, 3,3,'h1111,  3,3,'h2222,  1,3, 'h56AA,'h2222,   1,1, 0);
    vt[8]  = mk(0, 0,0,0,       0,0,0,       3,0, 'h2222,0,        1,0, 1);
    vt[9]  = mk(3, 3,1,'h1111,  3,2,'h2222,  3,3, 'h2211,'h2211,   1,1, 0);
    vt[10] = mk(0, 0,0,0,       0,0,0,       3,2, 'h2211,'hBEEF,   1,1, 0);
    vt[11] = mk(3, 0,3,'hAAAA,  0,2,'hBB00,  0,0, 'hBBAA,'hBBAA,   1,1, 0);
    vt[12] = mk(3, 0,3,'h00FF,  2,1,'h5555,  0,2, 'h00FF,'hBE55,   1,1, 1);
    vt[13] = mk(0, 0,0,0,       0,0,0,       0,2, 'h00FF,'hBE55,   1,1, 0);
    vt[14] = mk(0, 1,3,'hFFFF,  1,3,'hEEEE,  1,1, 'h56AA,'h56AA,   1,1, 0);
    vt[15] = mk(3, 1,0,'h1111,  1,3,'h7777,  1,0, 'h7777,'h00FF,   1,1, 0);
    vt[16] = mk(0, 0,0,0,       0,0,0,       1,3, 'h7777,'h2211,   1,1, 0);

    rst = 1'b0;
    im  = '0;
    inb = '0;
    iz  = '0;
    #2;
    chk("reset main rd0", rd_m[0], 16'h0);
    chk("reset main valid", 16'(v_m), 16'h0);
    chk("reset zr rd0", rd_z[0], 16'h0);
    chk("reset zr valid", 16'(v_z), 16'h0);
    #8 rst = 1'b1;

    // Table on the default (bypass, combinational read) instance.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      im = vt[k].i;
      #2;
      chk($sformatf("vec%0d rd0", k), rd_m[0], vt[k].e0);
      chk($sformatf("vec%0d rd1", k), rd_m[1], vt[k].e1);
      chk($sformatf("vec%0d valid", k), 16'(v_m), 16'(vt[k].ev));
      chk($sformatf("vec%0d conflict", k), 16'(cf_m), 16'(vt[k].ec));
    end
    @(negedge clk);
    im = '0;

    // No bypass: same-cycle read sees the old value, next cycle the new one.
    @(negedge clk);
    inb.en = 2'b01; inb.wa[0] = 2'd0; inb.be[0] = 2'b11; inb.wd[0] = 16'h00FF;
    inb.ra[0] = 2'd0; inb.ra[1] = 2'd0;
    #2;
    chk("nb same-cycle old", rd_n[0], 16'h0000);
    chk("nb same-cycle valid", 16'(v_n[0]), 16'h0);
    @(negedge clk);
    inb.en = 2'b10; inb.wa[1] = 2'd0; inb.be[1] = 2'b10; inb.wd[1] = 16'h1200;
    #2;
    chk("nb next-cycle new", rd_n[0], 16'h00FF);
    chk("nb next-cycle valid", 16'(v_n[0]), 16'h1);
    @(negedge clk);
    inb.en = 2'b00;
    #2;
    chk("nb port1 upper lane", rd_n[1], 16'h12FF);

    // Zero register with registered reads.
    @(negedge clk);
    iz.en = 2'b11; iz.wa[0] = 2'd0; iz.wa[1] = 2'd0; iz.be[0] = 2'b11; iz.be[1] = 2'b11;
    iz.wd[0] = 16'hFFFF; iz.wd[1] = 16'h1234; iz.ra[0] = 2'd0; iz.ra[1] = 2'd2;
    #2;
    chk("zr idle addr0 valid", 16'(v_z[0]), 16'h1);
    @(negedge clk);
    iz.en = 2'b01; iz.wa[0] = 2'd2; iz.be[0] = 2'b11; iz.wd[0] = 16'hCAFE;
    iz.ra[0] = 2'd2; iz.ra[1] = 2'd0;
    #2;
    chk("zr addr0 after write", rd_z[0], 16'h0000);
    chk("zr addr0 valid", 16'(v_z[0]), 16'h1);
    chk("zr addr2 unwritten", rd_z[1], 16'h0000);
    chk("zr addr2 invalid", 16'(v_z[1]), 16'h0);
    chk("zr no conflict on reg0", 16'(cf_z), 16'h0);
    @(negedge clk);
    iz.en = 2'b00; iz.ra[0] = 2'd2; iz.ra[1] = 2'd2;
    #2;
    chk("zr bypass at edge N", rd_z[0], 16'hCAFE);
    chk("zr bypass valid", 16'(v_z[0]), 16'h1);
    chk("zr held addr0 port1", rd_z[1], 16'h0000);
    @(negedge clk);
    iz.ra[0] = 2'd1; iz.ra[1] = 2'd2;
    #2;
    chk("zr port1 after edge", rd_z[1], 16'hCAFE);
    chk("zr port0 before edge", rd_z[0], 16'hCAFE);
    @(negedge clk);
    #2;
    chk("zr addr1 data", rd_z[0], 16'h0000);
    chk("zr addr1 invalid", 16'(v_z[0]), 16'h0);

    // Asynchronous reset mid-cycle, write during reset lost, first edge after release commits.
    @(negedge clk);
    im.en = 2'b11; im.wa[0] = 2'd1; im.wa[1] = 2'd1; im.be[0] = 2'b11; im.be[1] = 2'b11;
    im.wd[0] = 16'h0001; im.wd[1] = 16'h0002; im.ra[0] = 2'd1; im.ra[1] = 2'd3;
    @(negedge clk);
    im.en = 2'b00;
    #2;
    chk("pre-reset conflict", 16'(cf_m), 16'h1);
    chk("pre-reset rd0", rd_m[0], 16'h0002);
    #1 rst = 1'b0;
    #1;
    chk("async reset rd0", rd_m[0], 16'h0);
    chk("async reset rd1", rd_m[1], 16'h0);
    chk("async reset valid", 16'(v_m), 16'h0);
    chk("async reset conflict", 16'(cf_m), 16'h0);
    chk("async reset zr rd1", rd_z[1], 16'h0);
    @(negedge clk);
    im.en = 2'b01; im.wa[0] = 2'd3; im.be[0] = 2'b11; im.wd[0] = 16'hDEAD;
    @(negedge clk);
    rst = 1'b1;
    im.en = 2'b00; im.ra[0] = 2'd3; im.ra[1] = 2'd3;
    #2;
    chk("write in reset lost", rd_m[0], 16'h0);
    chk("write in reset invalid", 16'(v_m[0]), 16'h0);
    @(negedge clk);
    im.en = 2'b01; im.wa[0] = 2'd3; im.be[0] = 2'b11; im.wd[0] = 16'h4321;
    im.ra[0] = 2'd0; im.ra[1] = 2'd0;
    @(negedge clk);
    im.en = 2'b00; im.ra[0] = 2'd3; im.ra[1] = 2'd3;
    #2;
    chk("post-reset write", rd_m[0], 16'h4321);
    chk("post-reset valid", 16'(v_m[0]), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
